shift_receiver: RTL and testbench
=================================

SHIFT_RECEIVER -- requirements
Module: shift_receiver

Interface
REQ-001 SHALL have parameter W, default 4, giving the data word width in bits (W >= 2).
REQ-002 SHALL have port C, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port nR, input, 1 bit: synchronous active-low reset, sampled on the rising edge of C.
REQ-004 SHALL have port SI, input, 1 bit: serial data bit.
REQ-005 SHALL have port SV, input, 1 bit: SI valid; bits are consumed only on edges where SV=1.
REQ-006 SHALL have port F, input, 1 bit: frame start; F=1 with SV=1 marks the first (MSB) bit of a word.
REQ-007 SHALL have port Q, output, W bits: head word of the output buffer.
REQ-008 SHALL have port nQ, output, W bits: bitwise complement of Q at all times.
REQ-009 SHALL have port QV, output, 1 bit: Q holds a valid word.
REQ-010 SHALL have port QR, input, 1 bit: consumer ready; a word pops on an edge where QV=1 and QR=1.
REQ-011 SHALL have port OVF, output, 1 bit: sticky overflow flag.
REQ-012 SHALL have port ERR, output, 1 bit: one-cycle framing/parity error pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and, with the macro in REQ-025, PARITY.
REQ-014 In IDLE, SV=1 with F=1 SHALL load SI as the MSB, set bit count to 1, and go to SHIFT; SV=1 with F=0 SHALL be ignored.
REQ-015 In SHIFT, each SV=1 edge SHALL shift SI in, MSB first; SV=0 edges hold state, with no timeout.
REQ-016 On the Wth bit, the FSM SHALL complete the word and return to IDLE (or go to PARITY, per REQ-025).
REQ-017 In SHIFT or PARITY, SV=1 with F=1 SHALL discard the partial word, pulse ERR for one cycle, and restart with SI as the new MSB.
REQ-018 A completed word SHALL be pushed into a 2-entry FIFO; if the FIFO was empty, QV=1 and Q=word in the cycle after the completing edge.
REQ-019 A push and a pop on the same edge SHALL both take effect, including when the FIFO is full.
REQ-020 A push into a full FIFO with no simultaneous pop SHALL drop the new word, keep both stored words, and set OVF=1 until reset.
REQ-021 When the FIFO is empty, Q SHALL be all zeros and QV=0.
REQ-022 Word order out SHALL equal completion order.

Reset
REQ-023 On an edge with nR=0, the block SHALL go to IDLE, clear the bit count, empty the FIFO, and drive Q=0, nQ=all ones, QV=0, OVF=0, ERR=0.
REQ-024 A reset mid-word SHALL discard the partial word, and reset SHALL override all other inputs on that edge.

Configuration
REQ-025 With SHIFT_RECEIVER_PARITY_EN defined, the block SHALL require after the W data bits one even-parity bit (the XOR of data and parity equals 0), received in PARITY under SV. On a match the word is pushed; on a mismatch the word is discarded and ERR pulses. Without the macro, the PARITY state and its logic SHALL be absent and the word SHALL complete on the Wth bit.

Verification
REQ-026 Reset: nR=0 for one edge -> Q=0000, nQ=1111, QV=0, OVF=0, ERR=0.
REQ-027 Single word: QR=1, SI=1,0,1,1 with SV=1 and F=1 on the first bit -> QV=1, Q=1011, nQ=0100 for one cycle, then QV=0.
REQ-028 Overflow: QR=0, words 1111, 1110, 0001 -> OVF=1 after the third word; then QR=1 -> pops 1111 then 1110, and 0001 is never seen.
REQ-029 Abort: F=1 on bit 1, two bits, then F=1 again followed by 1,1,1,0 -> one ERR pulse, and only 1110 is delivered.
REQ-030 Gaps: bits 0,1,1,0 separated by 3 idle SV=0 cycles each -> Q=0110 is delivered, and ERR stays 0.
REQ-031 Parity (macro defined): 1011 with parity 1 -> delivered; 1011 with parity 0 -> ERR pulse, QV stays 0.

Source files
------------

// File: rtl/shift_receiver.sv
// -----------------------------------------------------------------------------
// shift_receiver
//
// Serial-to-parallel receiver. MSB-first bits are framed by F. Completed words
// go into a 2-entry FIFO that is drained through a valid/ready handshake.
//
// Optional feature: define SHIFT_RECEIVER_PARITY_EN to require one even-parity
// bit after the W data bits. A word with a bad parity bit is dropped and ERR
// pulses.
//
// Parameters:
//   W    data word width in bits (W >= 2)
//
// Ports:
//   C    in   clock, rising edge active
//   nR   in   synchronous active-low reset
//   SI   in   serial data bit
//   SV   in   SI valid; a bit is consumed only on edges where SV=1
//   F    in   frame start; F=1 together with SV=1 marks the MSB of a word
//   Q    out  [W-1:0] head word of the FIFO, all zeros when the FIFO is empty
//   nQ   out  [W-1:0] bitwise complement of Q
//   QV   out  Q holds a valid word
//   QR   in   consumer ready; the head word pops when QV=1 and QR=1
//   OVF  out  sticky overflow flag, cleared only by reset
//   ERR  out  one-cycle framing/parity error pulse
// -----------------------------------------------------------------------------
module shift_receiver #(
  parameter int W = 4
) (
  input  logic         C,
  input  logic         nR,
  input  logic         SI,
  input  logic         SV,
  input  logic         F,
  output logic [W-1:0] Q,
  output logic [W-1:0] nQ,
  output logic         QV,
  input  logic         QR,
  output logic         OVF,
  output logic         ERR
);

  localparam int CW = $clog2(W + 1);

`ifdef SHIFT_RECEIVER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic           err_q,   err_d;
  logic           ovf_q,   ovf_d;
  logic [W-1:0]   mem0_q,  mem0_d;   // head entry
  logic [W-1:0]   mem1_q,  mem1_d;
  logic [1:0]     fill_q,  fill_d;

  logic [W-1:0]   shifted;
  logic [W-1:0]   word;
  logic           push;
  logic           pop;

  assign shifted = {shreg_q[W-2:0], SI};

  // Framing FSM: next state, shift register and completed-word strobe.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    push    = 1'b0;
    word    = shreg_q;

    if (SV) begin
      if (F) begin
        // A frame start always restarts the word; it is an error only when
        // it cuts a word short.
        err_d   = (state_q != IDLE);
        state_d = SHIFT;
        shreg_d = {{(W-1){1'b0}}, SI};
        cnt_d   = CW'(1);
      end else begin
        case (state_q)
          IDLE: ;  // stray bits outside a frame are ignored
          SHIFT: begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
`ifdef SHIFT_RECEIVER_PARITY_EN
              state_d = PARITY;
`else
              state_d = IDLE;
              cnt_d   = '0;
              push    = 1'b1;
              word    = shifted;
`endif
            end
          end
`ifdef SHIFT_RECEIVER_PARITY_EN
          PARITY: begin
            // Even parity: data bits XOR parity bit must be zero.
            state_d = IDLE;
            cnt_d   = '0;
            if (^{shreg_q, SI} == 1'b0) push  = 1'b1;
            else                        err_d = 1'b1;
          end
`endif
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // Two-entry FIFO; mem0 is always the head, so a pop moves mem1 forward.
  assign QV  = (fill_q != 2'd0);
  assign pop = QV & QR;

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    fill_d = fill_q;
    ovf_d  = ovf_q;
    case ({push, pop})
      2'b10: begin
        case (fill_q)
          2'd0:    begin mem0_d = word; fill_d = 2'd1; end
          2'd1:    begin mem1_d = word; fill_d = 2'd2; end
          default: ovf_d = 1'b1;  // full: drop the new word
        endcase
      end
      2'b01: begin
        mem0_d = mem1_q;
        fill_d = fill_q - 2'd1;
      end
      2'b11: begin
        // Fill level is unchanged; the new word lands behind whatever remains.
        if (fill_q == 2'd1) begin
          mem0_d = word;
        end else begin
          mem0_d = mem1_q;
          mem1_d = word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge C) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!nR) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      fill_q  <= 2'd0;
      // NOTE: the FIFO data registers are cleared too; Q is masked by QV
      // anyway, but this keeps them free of X after reset at negligible cost.
      mem0_q  <= '0;
      mem1_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      fill_q  <= fill_d;
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
    end
  end

  assign Q   = QV ? mem0_q : '0;
  assign nQ  = ~Q;
  assign OVF = ovf_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_shift_receiver.sv
// -----------------------------------------------------------------------------
// tb_shift_receiver
//
// Directed bench for shift_receiver (W=4). Inputs change 1 ns after a rising
// edge and outputs are sampled there, so every check sees the result of the
// edge just taken. When SHIFT_RECEIVER_PARITY_EN is defined, each word also
// carries its even-parity bit and the parity cases are exercised.
// -----------------------------------------------------------------------------
module tb_shift_receiver;

  localparam int W = 4;

  logic         C;
  logic         nR;
  logic         SI;
  logic         SV;
  logic         F;
  logic [W-1:0] Q;
  logic [W-1:0] nQ;
  logic         QV;
  logic         QR;
  logic         OVF;
  logic         ERR;

  int vectors     = 0;
  int miscompares = 0;

  shift_receiver #(.W(W)) dut (
    .C   (C),
    .nR  (nR),
    .SI  (SI),
    .SV  (SV),
    .F   (F),
    .Q   (Q),
    .nQ  (nQ),
    .QV  (QV),
    .QR  (QR),
    .OVF (OVF),
    .ERR (ERR)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One valid bit on the next edge; SV and F drop afterwards.
  task automatic send_bit(input logic b, input logic f);
    SI = b;
    SV = 1'b1;
    F  = f;
    @(posedge C);
    #1;
    SV = 1'b0;
    F  = 1'b0;
  endtask

  task automatic idle(input int n);
    SV = 1'b0;
    F  = 1'b0;
    repeat (n) @(posedge C);
    #1;
  endtask

  // Full framed word, MSB first; QR takes qr_last for the completing edge.
  task automatic send_word(input logic [W-1:0] w, input logic qr_last);
    for (int i = W - 1; i >= 1; i--) send_bit(w[i], i == W - 1);
`ifdef SHIFT_RECEIVER_PARITY_EN
    send_bit(w[0], 1'b0);
    QR = qr_last;
    send_bit(^w, 1'b0);
`else
    QR = qr_last;
    send_bit(w[0], 1'b0);
`endif
  endtask

  initial begin
    nR = 1'b0;
    SI = 1'b0;
    SV = 1'b0;
    F  = 1'b0;
    QR = 1'b0;

    // Reset state
    @(posedge C);
    #1;
    check("rst_Q",   32'(Q),   32'h0);
    check("rst_nQ",  32'(nQ),  32'hF);
    check("rst_QV",  32'(QV),  32'h0);
    check("rst_OVF", 32'(OVF), 32'h0);
    check("rst_ERR", 32'(ERR), 32'h0);
    nR = 1'b1;

    // Single word, consumer always ready: visible for exactly one cycle
    QR = 1'b1;
    send_word(4'b1011, 1'b1);
    check("single_QV",  32'(QV),  32'h1);
    check("single_Q",   32'(Q),   32'hB);
    check("single_nQ",  32'(nQ),  32'h4);
    check("single_ERR", 32'(ERR), 32'h0);
    idle(1);
    check("single_pop_QV", 32'(QV), 32'h0);
    check("single_pop_Q",  32'(Q),  32'h0);

    // Gaps of 3 SV=0 cycles between bits 0,1,1,0
    send_bit(1'b0, 1'b1);
    idle(3);
    check("gap1_ERR", 32'(ERR), 32'h0);
    send_bit(1'b1, 1'b0);
    idle(3);
    check("gap2_QV", 32'(QV), 32'h0);
    send_bit(1'b1, 1'b0);
    idle(3);
    check("gap3_ERR", 32'(ERR), 32'h0);
`ifdef SHIFT_RECEIVER_PARITY_EN
    send_bit(1'b0, 1'b0);
    idle(3);
    send_bit(1'b0, 1'b0);
`else
    send_bit(1'b0, 1'b0);
`endif
    check("gap_QV",  32'(QV),  32'h1);
    check("gap_Q",   32'(Q),   32'h6);
    check("gap_ERR", 32'(ERR), 32'h0);
    idle(1);
    check("gap_pop_QV", 32'(QV), 32'h0);

    // Abort: two bits, then a new frame start carrying 1,1,1,0
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    check("abort_pre_ERR", 32'(ERR), 32'h0);
    send_bit(1'b1, 1'b1);
    check("abort_ERR", 32'(ERR), 32'h1);
    check("abort_QV",  32'(QV),  32'h0);
    send_bit(1'b1, 1'b0);
    check("abort_ERR_end", 32'(ERR), 32'h0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
`ifdef SHIFT_RECEIVER_PARITY_EN
    send_bit(1'b1, 1'b0);
`endif
    check("abort_word_QV", 32'(QV),  32'h1);
    check("abort_word_Q",  32'(Q),   32'hE);
    check("abort_ERR_0",   32'(ERR), 32'h0);
    idle(1);
    check("abort_pop_QV", 32'(QV), 32'h0);

    // Overflow: three words with the consumer stalled
    QR = 1'b0;
    send_word(4'b1111, 1'b0);
    check("ovf_w1_QV", 32'(QV), 32'h1);
    check("ovf_w1_Q",  32'(Q),  32'hF);
    send_word(4'b1110, 1'b0);
    check("ovf_w2_Q",   32'(Q),   32'hF);
    check("ovf_w2_OVF", 32'(OVF), 32'h0);
    send_word(4'b0001, 1'b0);
    check("ovf_w3_OVF", 32'(OVF), 32'h1);
    check("ovf_w3_Q",   32'(Q),   32'hF);
    QR = 1'b1;
    idle(1);
    check("ovf_pop1_Q",  32'(Q),  32'hE);
    check("ovf_pop1_QV", 32'(QV), 32'h1);
    idle(1);
    check("ovf_pop2_QV",  32'(QV),  32'h0);
    check("ovf_pop2_Q",   32'(Q),   32'h0);
    check("ovf_sticky",   32'(OVF), 32'h1);

    // Reset mid-word, with a frame start presented on the reset edge
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    nR = 1'b0;
    SI = 1'b1;
    SV = 1'b1;
    F  = 1'b1;
    @(posedge C);
    #1;
    nR = 1'b1;
    SV = 1'b0;
    F  = 1'b0;
    check("midrst_OVF", 32'(OVF), 32'h0);
    check("midrst_QV",  32'(QV),  32'h0);
    check("midrst_ERR", 32'(ERR), 32'h0);
    check("midrst_nQ",  32'(nQ),  32'hF);
    // Unframed bits after reset must be ignored
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("unframed_QV",  32'(QV),  32'h0);
    check("unframed_ERR", 32'(ERR), 32'h0);
    send_word(4'b1100, 1'b1);
    check("postrst_Q",  32'(Q),  32'hC);
    check("postrst_QV", 32'(QV), 32'h1);
    idle(1);

    // Push and pop on the same edge while the FIFO is full
    QR = 1'b0;
    send_word(4'b0011, 1'b0);
    send_word(4'b0101, 1'b0);
    send_word(4'b1001, 1'b1);
    check("pp_Q",   32'(Q),   32'h5);
    check("pp_QV",  32'(QV),  32'h1);
    check("pp_OVF", 32'(OVF), 32'h0);
    idle(1);
    check("pp_pop1_Q", 32'(Q), 32'h9);
    idle(1);
    check("pp_pop2_QV", 32'(QV), 32'h0);

`ifdef SHIFT_RECEIVER_PARITY_EN
    // Good parity is delivered, bad parity is dropped with an ERR pulse
    QR = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("par_ok_QV",  32'(QV),  32'h1);
    check("par_ok_Q",   32'(Q),   32'hB);
    check("par_ok_ERR", 32'(ERR), 32'h0);
    idle(1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("par_bad_ERR", 32'(ERR), 32'h1);
    check("par_bad_QV",  32'(QV),  32'h0);
    idle(1);
    check("par_bad_ERR_end", 32'(ERR), 32'h0);
    check("par_bad_QV_end",  32'(QV),  32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
